rx_udp_slot_buffer: RTL and testbench

Multi-slot receive buffer between the UDP receive stage and the RX payload memory. It replaces the single free-running RX address counter with a ring of 2^SLOT_CNT_W fixed-size slots, one packet per slot. Each slot stores the packet's byte length, and the block maintains occupancy, drops packets when full, and raises a per-packet interrupt. Software or the Wishbone side releases slots in order with a pop strobe.

---
 rtl/rx_udp_slot_buffer.sv | 126 ++++++++++++
 tb/tb_rx_udp_slot_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_udp_slot_buffer.sv
// rtl/rx_udp_slot_buffer.sv - ring of fixed-size RX packet slots with per-slot length, occupancy, drop and irq
// Optional drop counter output enabled by defining RX_SLOT_DROP_CNT_EN.
module rx_udp_slot_buffer #(
   parameter int OCT        = 8,
   parameter int SLOT_AW    = 11,
   parameter int SLOT_CNT_W = 2
) (
   input  logic                           RX_CLK,
   input  logic                           rst,
   input  logic                           rx_data_v,
   input  logic [OCT-1:0]                 rx_data,
   input  logic                           rx_done,
   input  logic                           rx_abort,
   output logic                           mem_we,
   output logic [SLOT_CNT_W+SLOT_AW-1:0]  mem_addr,
   output logic [OCT-1:0]                 mem_din,
   input  logic                           rd_pop,
   output logic [SLOT_CNT_W-1:0]          head_slot,
   output logic [SLOT_AW:0]               head_len,
   output logic [SLOT_CNT_W:0]            count,
   output logic                           full,
   output logic                           rx_irq
`ifdef RX_SLOT_DROP_CNT_EN
   ,
   output logic [15:0]                    drop_cnt
`endif
);
   localparam int NSLOT = 1 << SLOT_CNT_W;

   typedef enum logic [1:0] {IDLE, WRITE, HOLD, DROP} state_t;

   state_t                  state;
   logic [SLOT_AW:0]        wr_len;
   logic [SLOT_CNT_W-1:0]   head;
   logic [SLOT_CNT_W-1:0]   tail;
   logic [SLOT_AW:0]        len_mem [0:NSLOT-1];
   logic                    commit;
   logic                    pop_ok;
   logic                    start;

   // count never exceeds NSLOT, so its MSB alone marks the full condition
   assign full      = count[SLOT_CNT_W];
   assign head_slot = head;
   assign head_len  = len_mem[head];

   assign commit = (state == HOLD) && rx_done;
   assign pop_ok = rd_pop && (count != '0);
   assign start  = rx_data_v && ((state == IDLE) || ((state == HOLD) && !rx_done && !rx_abort));

   always_ff @(posedge RX_CLK) begin
      if (rst) begin
         state    <= IDLE;
         wr_len   <= '0;
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         rx_irq   <= 1'b0;
         for (int i = 0; i < NSLOT; i++) len_mem[i] <= '0;
      end else begin
         mem_we <= 1'b0;
         rx_irq <= commit;
         if (start) begin
            if (full) begin
               state <= DROP;
            end else begin
               state    <= WRITE;
               wr_len   <= (SLOT_AW+1)'(1);
               mem_we   <= 1'b1;
               mem_addr <= {tail, {SLOT_AW{1'b0}}};
               mem_din  <= rx_data;
            end
         end else begin
            case (state)
               WRITE: begin
                  if (!rx_data_v) begin
                     state <= HOLD;
                  end else if (!wr_len[SLOT_AW]) begin
                     mem_we   <= 1'b1;
                     mem_addr <= {tail, wr_len[SLOT_AW-1:0]};
                     mem_din  <= rx_data;
                     wr_len   <= wr_len + (SLOT_AW+1)'(1);
                  end
               end
               HOLD: begin
                  if (commit) begin
                     len_mem[tail] <= wr_len;
                     tail          <= tail + SLOT_CNT_W'(1);
                     state         <= IDLE;
                  end else if (rx_abort) begin
                     state <= IDLE;
                  end
               end
               DROP: begin
                  if (!rx_data_v) state <= IDLE;
               end
               default: ;
            endcase
         end
         if (commit && !pop_ok)
            count <= count + (SLOT_CNT_W+1)'(1);
         else if (pop_ok && !commit)
            count <= count - (SLOT_CNT_W+1)'(1);
         if (pop_ok) head <= head + SLOT_CNT_W'(1);
      end
   end

`ifdef RX_SLOT_DROP_CNT_EN
   logic drop_evt;

   // a packet is lost either when it arrives while full or when a held packet is discarded
   assign drop_evt = (start && full) ||
                     ((state == HOLD) && !rx_done && (rx_abort || rx_data_v));

   always_ff @(posedge RX_CLK) begin
      if (rst)
         drop_cnt <= '0;
      else if (drop_evt && (drop_cnt != 16'hFFFF))
         drop_cnt <= drop_cnt + 16'd1;
   end
`else
`endif

endmodule

// File: tb/tb_rx_udp_slot_buffer.sv
// tb/tb_rx_udp_slot_buffer.sv - directed and randomized check of rx_udp_slot_buffer against a packet-level model
module tb_rx_udp_slot_buffer;
   localparam int OCT        = 8;
   localparam int SLOT_AW    = 11;
   localparam int SLOT_CNT_W = 2;
   localparam int NSLOT      = 4;
   localparam int SLOT       = 2048;

   logic        RX_CLK    = 1'b0;
   logic        rst       = 1'b1;
   logic        rx_data_v = 1'b0;
   logic [7:0]  rx_data   = 8'h00;
   logic        rx_done   = 1'b0;
   logic        rx_abort  = 1'b0;
   logic        rd_pop    = 1'b0;
   wire         mem_we;
   wire  [12:0] mem_addr;
   wire  [7:0]  mem_din;
   wire  [1:0]  head_slot;
   wire  [11:0] head_len;
   wire  [2:0]  count;
   wire         full;
   wire         rx_irq;
`ifdef RX_SLOT_DROP_CNT_EN
   wire  [15:0] drop_cnt;
`endif

   rx_udp_slot_buffer #(.OCT(OCT), .SLOT_AW(SLOT_AW), .SLOT_CNT_W(SLOT_CNT_W)) dut (
      .RX_CLK    (RX_CLK),
      .rst       (rst),
      .rx_data_v (rx_data_v),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .rx_abort  (rx_abort),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .rd_pop    (rd_pop),
      .head_slot (head_slot),
      .head_len  (head_len),
      .count     (count),
      .full      (full),
      .rx_irq    (rx_irq)
`ifdef RX_SLOT_DROP_CNT_EN
      ,
      .drop_cnt  (drop_cnt)
`endif
   );

   always #5 RX_CLK = ~RX_CLK;

   int   total = 0;
   int   bad   = 0;
   logic exp_we  = 1'b0;
   logic exp_irq = 1'b0;
   int   exp_addr = 0;
   int   exp_din  = 0;

   // model: committed packet lengths in arrival order plus ring indices
   int   m_q[$];
   int   m_head = 0;
   int   m_tail = 0;
   int   m_drop = 0;
   bit   m_held = 1'b0;
   bit   m_accept = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge RX_CLK);
      #1;
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (exp_we) begin
         chk("mem_addr", 32'(mem_addr), exp_addr);
         chk("mem_din", 32'(mem_din), exp_din);
      end
      chk("rx_irq", 32'(rx_irq), 32'(exp_irq));
      exp_we  = 1'b0;
      exp_irq = 1'b0;
   endtask

   task automatic check_state(input string tag);
      chk({tag, ".count"}, 32'(count), m_q.size());
      chk({tag, ".full"}, 32'(full), 32'(m_q.size() == NSLOT));
      if (m_q.size() > 0) begin
         chk({tag, ".head_slot"}, 32'(head_slot), m_head);
         chk({tag, ".head_len"}, 32'(head_len), m_q[0]);
      end
`ifdef RX_SLOT_DROP_CNT_EN
      chk({tag, ".drop_cnt"}, 32'(drop_cnt), m_drop);
`endif
   endtask

   task automatic drive_bytes(input int n, input int base);
      if (m_held) m_drop++;
      m_held   = 1'b0;
      m_accept = (m_q.size() < NSLOT);
      if (!m_accept) m_drop++;
      for (int i = 0; i < n; i++) begin
         rx_data_v = 1'b1;
         rx_data   = (base < 0) ? 8'($urandom) : 8'(base + i);
         exp_we    = m_accept && (i < SLOT);
         exp_addr  = m_tail * SLOT + i;
         exp_din   = int'(rx_data);
         tick();
      end
   endtask

   // verdict: 0 none, 1 done, 2 abort
   task automatic send_packet(input string tag, input int n, input int base, input int verdict, input bit pop_also);
      drive_bytes(n, base);
      rx_data_v = 1'b0;
      tick();
      rx_done  = (verdict == 1);
      rx_abort = (verdict == 2);
      rd_pop   = pop_also;
      exp_irq  = m_accept && (verdict == 1);
      tick();
      rx_done  = 1'b0;
      rx_abort = 1'b0;
      rd_pop   = 1'b0;
      if (pop_also && m_q.size() > 0) begin
         void'(m_q.pop_front());
         m_head = (m_head + 1) % NSLOT;
      end
      if (m_accept) begin
         if (verdict == 1) begin
            m_q.push_back((n < SLOT) ? n : SLOT);
            m_tail = (m_tail + 1) % NSLOT;
         end else if (verdict == 2) begin
            m_drop++;
         end else begin
            m_held = 1'b1;
         end
      end
      check_state(tag);
   endtask

   task automatic pop();
      rd_pop = 1'b1;
      tick();
      rd_pop = 1'b0;
      if (m_q.size() > 0) begin
         void'(m_q.pop_front());
         m_head = (m_head + 1) % NSLOT;
      end
      check_state("pop");
   endtask

   task automatic model_reset();
      m_q.delete();
      m_head = 0;
      m_tail = 0;
      m_drop = 0;
      m_held = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_data_v = 1'b0;
      rx_done = 1'b0;
      rx_abort = 1'b0;
      rd_pop = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      check_state("reset");
   endtask

   initial begin
      tick();
      chk("reset.mem_addr", 32'(mem_addr), 0);
      chk("reset.mem_din", 32'(mem_din), 0);
      do_reset();

      send_packet("pkt10", 10, 0, 1, 1'b0);

      do_reset();
      send_packet("abort5", 5, 8'h20, 2, 1'b0);
      send_packet("done3", 3, 8'h30, 1, 1'b0);

      do_reset();
      for (int k = 0; k < NSLOT; k++) send_packet("fill", 4 + k, -1, 1, 1'b0);
      send_packet("drop5", 5, -1, 1, 1'b0);
      pop();
      send_packet("wrap6", 6, 8'h60, 1, 1'b0);

      do_reset();
      send_packet("trunc", SLOT + 6, -1, 1, 1'b0);

      do_reset();
      send_packet("cp_a", 7, -1, 1, 1'b0);
      send_packet("cp_b", 8, -1, 1, 1'b0);
      send_packet("cp_c", 9, -1, 1, 1'b1);

      do_reset();
      drive_bytes(4, 8'h40);
      rst = 1'b1;
      rx_data = 8'h44;
      tick();
      model_reset();
      check_state("rst_mid");
      rst = 1'b0;
      rx_data_v = 1'b0;
      tick();
      send_packet("after_rst", 6, 8'h50, 1, 1'b0);

      send_packet("hold", 5, -1, 0, 1'b0);
      send_packet("restart", 4, -1, 1, 1'b0);

      for (int k = 0; k < 40; k++) begin
         send_packet("rand", $urandom_range(1, 24), -1, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
         if ($urandom_range(0, 2) == 0) pop();
      end
      for (int k = 0; k < NSLOT + 1; k++) pop();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
